// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer
//   Small in-order FIFO between instruction memory and the decoder. Each
//   accepted word is stored with the fetch address (PC) it was fetched at.
//   Consuming a halt opcode freezes delivery until resume. Flush empties the
//   buffer and reloads the fetch counter with a jump target.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   mem_ins, ins_valid      incoming word {opcode, address}; valid strobe
//   ins_ready               buffer can accept a word
//   dec_ready, dec_valid    decoder handshake on the head entry
//   Opcode_out, Address_out, Pc_out  head entry fields
//   flush, flush_addr       discard all entries; new fetch counter value
//   resume                  leave the halted state
//   halted                  a halt opcode has been consumed
//   count                   occupied entries
module instruction_fetch_buffer #(
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned HLT_OPC = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [OPC_W+ADDR_W-1:0]   mem_ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  input  logic                      dec_ready,
  output logic                      dec_valid,
  output logic [OPC_W-1:0]          Opcode_out,
  output logic [ADDR_W-1:0]         Address_out,
  output logic [ADDR_W-1:0]         Pc_out,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         flush_addr,
  input  logic                      resume,
  output logic                      halted,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [OPC_W-1:0] HLT_C   = OPC_W'(HLT_OPC);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   fpc_q, fpc_d;
  logic                push_en, pop_en;

  logic [OPC_W-1:0]    opc_q  [DEPTH];
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q   [DEPTH];

  // Handshakes depend only on registered state, never on dec_ready.
  assign halted      = (state_q == ST_HALT);
  assign ins_ready   = (cnt_q < DEPTH_C) && !halted;
  assign dec_valid   = (cnt_q != '0) && !halted;
  assign count       = cnt_q;
  assign Opcode_out  = opc_q[rd_ptr_q];
  assign Address_out = addr_q[rd_ptr_q];
  assign Pc_out      = pc_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    fpc_d    = fpc_q;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    if (flush) begin
      state_d  = ST_RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      fpc_d    = flush_addr;
    end else begin
      push_en = ins_valid && ins_ready;
      pop_en  = dec_valid && dec_ready;
      if (push_en) begin
        // Pointers and fetch counter wrap naturally at their widths.
        wr_ptr_d = wr_ptr_q + 1'b1;
        fpc_d    = fpc_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (opc_q[rd_ptr_q] == HLT_C) state_d = ST_HALT;
      end
      case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if ((state_q == ST_HALT) && resume) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      fpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      fpc_q    <= fpc_d;
    end
  end

  // Storage is reset too so the head fields read zero straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        opc_q[i]  <= '0;
        addr_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push_en) begin
      opc_q[wr_ptr_q]  <= mem_ins[OPC_W+ADDR_W-1:ADDR_W];
      addr_q[wr_ptr_q] <= mem_ins[ADDR_W-1:0];
      pc_q[wr_ptr_q]   <= fpc_q;
    end
  end

endmodule
